// File: rtl/dds_seq_pkg.sv
// Shared types and default sizing for the DDS sample sequencer.
// Defaults match the CORDIC DDS core it drives.
package dds_seq_pkg;

  localparam int INC_W_DEF   = 20;
  localparam int Q_W_DEF     = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int DEPTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP,
    FIN
  } state_e;

endpackage

// File: rtl/dds_sample_fifo.sv
// First-word-fall-through sample FIFO; the head entry is always visible on dout.
// Pointers wrap naturally because DEPTH is a power of two.
module dds_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only accepted when a pop frees the slot that same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/dds_sample_sequencer.sv
// Drives update strobes into the DDS core, captures each sample on the ready
// rising edge into a FWFT FIFO, and runs bursts of N samples with a timeout.
module dds_sample_sequencer
  import dds_seq_pkg::*;
#(
  parameter int INC_W   = INC_W_DEF,
  parameter int Q_W     = Q_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [INC_W-1:0] step_in,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [7:0]       period,
  output logic [INC_W-1:0] dds_increment,
  output logic             dds_update,
  input  logic [Q_W-1:0]   dds_q,
  input  logic             dds_ready,
  output logic [Q_W-1:0]   smp_data,
  output logic             smp_valid,
  input  logic             smp_accept,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic [INC_W-1:0] inc_q;
  logic [CNT_W-1:0] remain_q;
  logic [7:0]       period_q;
  logic [7:0]       gap_q;
  logic [TW-1:0]    tmo_q;
  logic             ready_q;
  logic             update_q;
  logic             done_q;
  logic             err_q;

  logic             ready_edge;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             room_nxt;

  assign ready_edge = dds_ready & ~ready_q;
  assign fifo_push  = (state_q == WAIT) && ready_edge;
  assign smp_valid  = ~fifo_empty;
  assign fifo_pop   = smp_valid & smp_accept;
  // Pushes only happen in WAIT, so next-cycle room depends on the pop alone.
  assign room_nxt   = (fifo_count != CW'(DEPTH)) || fifo_pop;

  dds_sample_fifo #(
    .W     (Q_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (dds_q),
    .pop   (fifo_pop),
    .dout  (smp_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The update strobe is registered: it is armed on entry to ISSUE when the FIFO will have room.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      inc_q    <= '0;
      remain_q <= '0;
      period_q <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
      ready_q  <= 1'b0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q  <= dds_ready;
      update_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            inc_q    <= step_in;
            remain_q <= num_samples;
            period_q <= period;
            err_q    <= 1'b0;
            if (num_samples == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ISSUE;
              update_q <= room_nxt;
            end
          end
        end
        ISSUE: begin
          if (update_q) begin
            tmo_q   <= '0;
            state_q <= WAIT;
          end else begin
            update_q <= room_nxt;
          end
        end
        WAIT: begin
          if (ready_edge) begin
            remain_q <= remain_q - 1'b1;
            if (remain_q == CNT_W'(1)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= GAP;
              gap_q   <= period_q;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q  <= ISSUE;
            update_q <= room_nxt;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dds_increment = inc_q;
  assign dds_update    = update_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_dds_sample_sequencer.sv
// Directed bench for dds_sample_sequencer with a behavioural DDS responder
// and a consumer monitor; each scenario task checks its own expectations.
module tb_dds_sample_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [19:0] step_in;
  logic [15:0] num_samples;
  logic [7:0]  period;
  logic [19:0] dds_increment;
  logic        dds_update;
  logic [15:0] dds_q;
  logic        dds_ready;
  logic [15:0] smp_data;
  logic        smp_valid;
  logic        smp_accept;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int checks;
  int passes;
  int cycle;
  int updCount;
  int doneCount;
  int respDelay;
  int respIdx;
  int waitCnt;
  bit ddsRespond;
  bit readyPulse;
  logic [15:0] qTable [16];
  logic [15:0] popped [$];
  int updCycles [$];
  int fireCycles [$];

  dds_sample_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .step_in       (step_in),
    .num_samples   (num_samples),
    .period        (period),
    .dds_increment (dds_increment),
    .dds_update    (dds_update),
    .dds_q         (dds_q),
    .dds_ready     (dds_ready),
    .smp_data      (smp_data),
    .smp_valid     (smp_valid),
    .smp_accept    (smp_accept),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // DDS responder: one-cycle ready pulse respDelay cycles after each update.
  always @(negedge clk) begin
    if (readyPulse) begin
      dds_ready  = 1'b0;
      readyPulse = 1'b0;
    end
    if (dds_update) begin
      updCount++;
      updCycles.push_back(cycle);
      if (ddsRespond) waitCnt = respDelay;
    end else if (waitCnt > 0) begin
      waitCnt--;
      if (waitCnt == 0) begin
        dds_q      = qTable[respIdx];
        respIdx++;
        dds_ready  = 1'b1;
        readyPulse = 1'b1;
        fireCycles.push_back(cycle);
      end
    end
  end

  always @(negedge clk) begin
    if (smp_valid && smp_accept) popped.push_back(smp_data);
    if (done) doneCount++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearLogs();
    popped.delete();
    updCycles.delete();
    fireCycles.delete();
    updCount  = 0;
    doneCount = 0;
    respIdx   = 0;
    waitCnt   = 0;
  endtask

  task automatic pulseStart(input logic [19:0] s, input logic [15:0] n, input logic [7:0] p);
    step_in     = s;
    num_samples = n;
    period      = p;
    start       = 1'b1;
    tick(1);
    start       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; step_in = 20'hFFFFF; num_samples = 16'd5; period = 8'd1;
    tick(3);
    checks++; if (dds_increment !== 20'h0) $display("[TB] FAIL rst_increment: got %h expected 00000", dds_increment); else passes++;
    checks++; if (dds_update !== 1'b0) $display("[TB] FAIL rst_update: got %b expected 0", dds_update); else passes++;
    checks++; if (smp_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", smp_valid); else passes++;
    checks++; if (smp_data !== 16'h0) $display("[TB] FAIL rst_data: got %h expected 0000", smp_data); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rst_done: got %b expected 0", done); else passes++;
    checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL rst_err: got %b expected 0", timeout_err); else passes++;
    checks++; if (updCount !== 0) $display("[TB] FAIL rst_no_update: got %0d expected 0", updCount); else passes++;
    start = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_burst();
    clearLogs();
    ddsRespond = 1'b1; respDelay = 20; smp_accept = 1'b1;
    qTable[0] = 16'h1234; qTable[1] = 16'h5678; qTable[2] = 16'h9ABC;
    step_in = 20'h00400; num_samples = 16'd3; period = 8'd4; start = 1'b1;
    checks++; if (dds_update !== 1'b0) $display("[TB] FAIL lat_start_cycle: got %b expected 0", dds_update); else passes++;
    tick(1);
    start = 1'b0;
    checks++; if (dds_update !== 1'b1) $display("[TB] FAIL lat_issue_cycle: got %b expected 1", dds_update); else passes++;
    checks++; if (dds_increment !== 20'h00400) $display("[TB] FAIL burst_increment: got %h expected 00400", dds_increment); else passes++;
    tick(1);
    checks++; if (dds_update !== 1'b0) $display("[TB] FAIL update_single: got %b expected 0", dds_update); else passes++;
    for (int i = 0; i < 400 && doneCount == 0; i++) tick(1);
    tick(4);
    checks++; if (doneCount !== 1) $display("[TB] FAIL burst_done: got %0d expected 1", doneCount); else passes++;
    checks++; if (updCount !== 3) $display("[TB] FAIL burst_updates: got %0d expected 3", updCount); else passes++;
    checks++; if (popped.size() !== 3) $display("[TB] FAIL burst_pops: got %0d expected 3", popped.size()); else passes++;
    for (int k = 0; k < 3 && k < popped.size(); k++) begin
      checks++; if (popped[k] !== qTable[k]) $display("[TB] FAIL burst_data%0d: got %h expected %h", k, popped[k], qTable[k]); else passes++;
    end
    for (int k = 1; k < 3 && k < updCycles.size() && k <= fireCycles.size(); k++) begin
      checks++; if (updCycles[k] - fireCycles[k-1] < 5) $display("[TB] FAIL burst_gap%0d: got %0d expected >=5", k, updCycles[k] - fireCycles[k-1]); else passes++;
    end
    checks++; if (busy !== 1'b0) $display("[TB] FAIL burst_idle: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_backpressure();
    clearLogs();
    ddsRespond = 1'b1; respDelay = 3; smp_accept = 1'b0;
    for (int k = 0; k < 16; k++) qTable[k] = 16'hA000 + 16'(k);
    pulseStart(20'h01000, 16'd12, 8'd0);
    tick(200);
    checks++; if (updCount !== 8) $display("[TB] FAIL bp_stall_updates: got %0d expected 8", updCount); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL bp_stall_busy: got %b expected 1", busy); else passes++;
    checks++; if (dds_update !== 1'b0) $display("[TB] FAIL bp_stall_strobe: got %b expected 0", dds_update); else passes++;
    checks++; if (smp_data !== 16'hA000) $display("[TB] FAIL bp_head: got %h expected a000", smp_data); else passes++;
    smp_accept = 1'b1;
    for (int i = 0; i < 400 && doneCount == 0; i++) tick(1);
    tick(4);
    checks++; if (updCount !== 12) $display("[TB] FAIL bp_updates: got %0d expected 12", updCount); else passes++;
    checks++; if (popped.size() !== 12) $display("[TB] FAIL bp_pops: got %0d expected 12", popped.size()); else passes++;
    for (int k = 0; k < 12 && k < popped.size(); k++) begin
      checks++; if (popped[k] !== 16'hA000 + 16'(k)) $display("[TB] FAIL bp_data%0d: got %h expected %h", k, popped[k], 16'hA000 + 16'(k)); else passes++;
    end
    checks++; if (doneCount !== 1) $display("[TB] FAIL bp_done: got %0d expected 1", doneCount); else passes++;
  endtask

  task automatic test_timeout();
    clearLogs();
    ddsRespond = 1'b0; smp_accept = 1'b1;
    pulseStart(20'h00010, 16'd1, 8'd0);
    checks++; if (dds_update !== 1'b1) $display("[TB] FAIL to_update: got %b expected 1", dds_update); else passes++;
    tick(1024);
    checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL to_early: got %b expected 0", timeout_err); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL to_busy_before: got %b expected 1", busy); else passes++;
    tick(1);
    checks++; if (timeout_err !== 1'b1) $display("[TB] FAIL to_flag: got %b expected 1", timeout_err); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL to_busy_after: got %b expected 0", busy); else passes++;
    tick(3);
    checks++; if (doneCount !== 0) $display("[TB] FAIL to_no_done: got %0d expected 0", doneCount); else passes++;
    checks++; if (timeout_err !== 1'b1) $display("[TB] FAIL to_sticky: got %b expected 1", timeout_err); else passes++;
    pulseStart(20'h00020, 16'd0, 8'd0);
    checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL to_cleared: got %b expected 0", timeout_err); else passes++;
    tick(2);
  endtask

  task automatic test_zero_and_ignore();
    clearLogs();
    ddsRespond = 1'b1; respDelay = 10; smp_accept = 1'b1;
    pulseStart(20'h00033, 16'd0, 8'd3);
    checks++; if (done !== 1'b1) $display("[TB] FAIL zero_done: got %b expected 1", done); else passes++;
    checks++; if (dds_update !== 1'b0) $display("[TB] FAIL zero_update: got %b expected 0", dds_update); else passes++;
    tick(1);
    checks++; if (done !== 1'b0) $display("[TB] FAIL zero_done_once: got %b expected 0", done); else passes++;
    checks++; if (smp_valid !== 1'b0) $display("[TB] FAIL zero_fifo: got %b expected 0", smp_valid); else passes++;
    checks++; if (updCount !== 0) $display("[TB] FAIL zero_no_update: got %0d expected 0", updCount); else passes++;
    clearLogs();
    qTable[0] = 16'h0101; qTable[1] = 16'h0202;
    pulseStart(20'h00111, 16'd2, 8'd2);
    tick(5);
    pulseStart(20'h22222, 16'd5, 8'd0);
    for (int i = 0; i < 300 && doneCount == 0; i++) tick(1);
    tick(4);
    checks++; if (updCount !== 2) $display("[TB] FAIL ign_updates: got %0d expected 2", updCount); else passes++;
    checks++; if (popped.size() !== 2) $display("[TB] FAIL ign_pops: got %0d expected 2", popped.size()); else passes++;
    checks++; if (dds_increment !== 20'h00111) $display("[TB] FAIL ign_increment: got %h expected 00111", dds_increment); else passes++;
    checks++; if (doneCount !== 1) $display("[TB] FAIL ign_done: got %0d expected 1", doneCount); else passes++;
  endtask

  task automatic test_reset_mid();
    clearLogs();
    ddsRespond = 1'b1; respDelay = 4; smp_accept = 1'b0;
    qTable[0] = 16'h0AAA; qTable[1] = 16'h0BBB; qTable[2] = 16'h0CCC;
    pulseStart(20'h00444, 16'd3, 8'd0);
    for (int i = 0; i < 100 && updCount < 3; i++) tick(1);
    checks++; if (updCount !== 3) $display("[TB] FAIL mid_reach_wait: got %0d expected 3", updCount); else passes++;
    checks++; if (smp_valid !== 1'b1) $display("[TB] FAIL mid_fifo_full2: got %b expected 1", smp_valid); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (smp_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %b expected 0", smp_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy: got %b expected 0", busy); else passes++;
    tick(1);
    reset = 1'b1;
    tick(10);
    checks++; if (respIdx !== 3) $display("[TB] FAIL mid_late_edge: got %0d expected 3", respIdx); else passes++;
    checks++; if (smp_valid !== 1'b0) $display("[TB] FAIL mid_no_write: got %b expected 0", smp_valid); else passes++;
    checks++; if (doneCount !== 0) $display("[TB] FAIL mid_no_done: got %0d expected 0", doneCount); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0; cycle = 0;
    ddsRespond = 1'b0; readyPulse = 1'b0; respDelay = 20;
    dds_ready = 1'b0; dds_q = 16'h0; smp_accept = 1'b0;
    reset = 1'b0; start = 1'b0; step_in = '0; num_samples = '0; period = '0;
    for (int k = 0; k < 16; k++) qTable[k] = 16'h0;
    clearLogs();
    test_reset();
    test_burst();
    test_backpressure();
    test_timeout();
    test_zero_and_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
